console_tx: RTL and testbench

//  Display-side responder for the eLC-3 memory-mapped console. Accepts DDR store strobes from

---
 rtl/elc3_pkg.sv | 14 +
 rtl/console_tx_sync_fifo.sv | 49 ++++
 rtl/console_tx.sv | 106 ++++++++++
 tb/tb_console_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/elc3_pkg.sv
// Shared eLC-3 console definitions: transmitter FSM states and the console register map.
package elc3_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [15:0] DSR_ADDR = 16'hFE04;
  localparam logic [15:0] DDR_ADDR = 16'hFE06;

  // Clocks per serial bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/console_tx_sync_fifo.sv
// Small synchronous FIFO with a show-ahead head; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd];

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/console_tx.sv
// eLC-3 console display responder: buffers DDR store bytes and sends them as 8N1 UART frames.
module console_tx
  import elc3_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        DDR_Write,
  input  logic [15:0] DDR_Data,
  output logic        DSR_Ready,
  output logic        TX,
  output logic        Busy,
  output logic        Overrun,
  output logic [7:0]  Last_Char
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);

  tx_state_t      r_state, w_state_nxt;
  logic [CW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_tx, w_tx_nxt;
  logic           r_overrun;
  logic [7:0]     r_last;
  logic           w_full, w_empty, w_pop, w_tick;
  logic [7:0]     w_head;
  logic           w_unused_hi;

  assign w_unused_hi = &{1'b0, DDR_Data[15:8]};
  assign w_tick      = (r_baud == CW'(DIV - 1));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .push    (DDR_Write),
    .pop     (w_pop),
    .din     (DDR_Data[7:0]),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
      DATA:  if (w_tick && r_bit == 3'd7) w_state_nxt = STOP;
      STOP:  if (w_tick) w_state_nxt = w_empty ? IDLE : START;
      default: w_state_nxt = IDLE;
    endcase
  end

  // TX is registered, so its next value follows the next state and next shift contents.
  always_comb begin
    w_pop       = 1'b0;
    w_shift_nxt = r_shift;
    if ((r_state == IDLE && !w_empty) || (r_state == STOP && w_tick && !w_empty))
      w_pop = 1'b1;
    if (w_pop)
      w_shift_nxt = w_head;
    else if (r_state == DATA && w_tick)
      w_shift_nxt = {1'b0, r_shift[7:1]};
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_overrun <= 1'b0;
      r_last    <= 8'h00;
    end else begin
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (r_state == IDLE || w_tick) r_baud <= '0;
      else                           r_baud <= r_baud + 1'b1;
      if (r_state == START && w_tick)     r_bit <= '0;
      else if (r_state == DATA && w_tick) r_bit <= r_bit + 1'b1;
      if (DDR_Write && !w_full) r_last    <= DDR_Data[7:0];
      if (DDR_Write && w_full)  r_overrun <= 1'b1;
    end
  end

  assign DSR_Ready = ~w_full;
  assign TX        = r_tx;
  assign Busy      = (r_state != IDLE) | ~w_empty;
  assign Overrun   = r_overrun;
  assign Last_Char = r_last;

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx: directed scenarios plus random writes against a frame-timer model.
module tb_console_tx;
  localparam int FD  = 4;
  localparam int DIV = (1000 + 100 / 2) / 100;
  localparam int FRM = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] wdat = '0;
  logic        dsr, tx, busy, ovr;
  logic [7:0]  last;

  int n_chk = 0;
  int n_err = 0;

  console_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(FD)) dut (
    .Clk(clk), .Reset_N(rst_n), .DDR_Write(wr), .DDR_Data(wdat),
    .DSR_Ready(dsr), .TX(tx), .Busy(busy), .Overrun(ovr), .Last_Char(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a queue of pending bytes and a clock count since the current frame began.
  logic [7:0] m_q[$];
  logic [7:0] m_cur, m_last;
  bit         m_act, m_ovr, m_pop, m_full;
  int         m_t, m_sz;
  logic       m_tx;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete(); m_act = 0; m_t = 0; m_ovr = 0; m_last = 8'h00;
    end else begin
      m_sz = m_q.size(); m_full = (m_sz == FD); m_pop = 0;
      if (m_act) begin
        m_t++;
        if (m_t == FRM) begin
          if (m_sz > 0) begin m_pop = 1; m_t = 0; end
          else m_act = 0;
        end
      end else if (m_sz > 0) begin
        m_pop = 1; m_act = 1; m_t = 0;
      end
      if (m_pop) m_cur = m_q.pop_front();
      if (wr) begin
        if (!m_full) begin m_q.push_back(wdat[7:0]); m_last = wdat[7:0]; end
        else m_ovr = 1;
      end
    end
    #1;
    if (!m_act)              m_tx = 1'b1;
    else if (m_t < DIV)      m_tx = 1'b0;
    else if (m_t < 9 * DIV)  m_tx = m_cur[m_t / DIV - 1];
    else                     m_tx = 1'b1;
    chk("tx",   16'(tx),   16'(m_tx));
    chk("dsr",  16'(dsr),  16'(m_q.size() < FD));
    chk("busy", 16'(busy), 16'(m_act || m_q.size() > 0));
    chk("ovr",  16'(ovr),  16'(m_ovr));
    chk("last", 16'(last), 16'(m_last));
  end

  task automatic put(input logic [15:0] d);
    wr = 1'b1; wdat = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk("idle_timeout", 16'(busy), 16'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx), 16'd1);
    chk("rst_dsr", 16'(dsr), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_last", 16'(last), 16'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single character, upper byte ignored
    put(16'hAB41);
    chk("t1_last", 16'(last), 16'h41);
    n = 0;
    while (tx && n < 10) begin @(negedge clk); n++; end
    chk("t1_tx_fall", 16'(n), 16'd1);
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk("t1_busy_len", 16'(n), 16'(FRM));

    // 2: five back-to-back writes
    for (int i = 0; i < 5; i++) put(16'(8'h41 + i));
    chk("t2_dsr_full", 16'(dsr), 16'd0);
    wait_idle(700);

    // 3: overrun while full
    for (int i = 0; i < 5; i++) put(16'(8'h61 + i));
    put(16'h005A);
    chk("t3_ovr", 16'(ovr), 16'd1);
    wait_idle(700);
    repeat (20) @(negedge clk);
    chk("t3_ovr_hold", 16'(ovr), 16'd1);

    // 4: write while full on the edge the frame end pops
    pulse_reset();
    for (int i = 0; i < 5; i++) put(16'(8'h30 + i));
    n = 0;
    while (!(m_act && m_t == FRM - 1 && m_q.size() == FD) && n < 300) begin @(negedge clk); n++; end
    chk("t4_sync_timeout", 16'(n < 300), 16'd1);
    put(16'h0077);
    chk("t4_dsr", 16'(dsr), 16'd1);
    chk("t4_ovr", 16'(ovr), 16'd1);
    wait_idle(700);

    // 5: reset during data bit 3
    put(16'h00C3);
    n = 0;
    while (!(m_act && m_t == 4 * DIV + 3) && n < 200) begin @(negedge clk); n++; end
    chk("t5_sync_timeout", 16'(n < 200), 16'd1);
    pulse_reset();
    chk("t5_tx", 16'(tx), 16'd1);
    chk("t5_dsr", 16'(dsr), 16'd1);
    chk("t5_ovr", 16'(ovr), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    put(16'h0055);
    wait_idle(300);

    // 6: nine characters in pairs to wrap the pointers
    for (int i = 0; i < 9; i += 2) begin
      put(16'(8'h80 + i));
      if (i + 1 < 9) put(16'(8'h80 + i + 1));
      wait_idle(400);
    end

    // random traffic with rare resets
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1999) == 0) pulse_reset();
      else if ($urandom_range(0, 99) < 8) put(16'($urandom));
      else @(negedge clk);
    end
    wait_idle(800);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
